ceespu_gshare_predictor: RTL
============================

// Module: ceespu_gshare_predictor
// PURPOSE
//  Parametrised gshare successor to ceespu_branch_predictor. Sits in fetch/decode: looks up a table of
//  CNT_W-bit saturating counters indexed by PC XOR global history, predicts taken/not-taken, and is
//  trained by execute with the index, counter and history carried down the pipe. Speculative history
//  with recovery on mispredict. HIST_W=0 degenerates to the bimodal (PC-indexed) predictor.
// PARAMETERS
//  PC_W          16     width of I_pc / branch_address
//  IDX_W         6      table index width; table depth = 2**IDX_W
//  HIST_W        4      global history bits (0..IDX_W); 0 = bimodal mode
//  CNT_W         2      counter width (>=2); MSB = predict taken
//  BRANCH_OPCODE 6'h39  I_instruction[31:26] value identifying a conditional branch
// PORTS
//  clk                      in   1       clock, rising edge
//  rst                      in   1       asynchronous, active-high reset
//  I_instruction            in   32      instruction in decode
//  I_pc                     in   PC_W    address of I_instruction
//  I_stall                  in   1       1 = no lookup this cycle; outputs and history hold
//  prediction_valid         out  1       registered; 1 = outputs below belong to a branch looked up last cycle
//  prediction               out  1       registered taken prediction
//  prediction_state         out  CNT_W   counter value used for the prediction
//  prediction_index         out  IDX_W   table index used (carried to execute)
//  prediction_history       out  max(HIST_W,1)  GHR before this branch's speculative shift
//  update_table             in   1       1 = train one entry this cycle
//  branch_address           in   PC_W    address of resolved branch (debug/assertions only)
//  branch_index             in   IDX_W   index returned with the prediction
//  branch_prediction_state  in   CNT_W   counter value returned with the prediction
//  branch_history           in   max(HIST_W,1)  history returned with the prediction
//  branch_taken             in   1       resolved outcome
// BEHAVIOUR
//  Reset (async, immediate): all counters = 2**(CNT_W-1)-1 (weakly not-taken, 2'b01); GHR = 0;
//   prediction_valid=0, prediction=0, prediction_state=reset counter value, prediction_index=0,
//   prediction_history=0. Reset mid-training discards all learned state in that cycle.
//  Lookup: when !I_stall and I_instruction[31:26]==BRANCH_OPCODE:
//   idx = I_pc[IDX_W-1:0] ^ {{(IDX_W-HIST_W){1'b0}}, GHR}; cnt = table[idx] (with bypass below).
//   Next edge: prediction_valid=1, prediction=cnt[CNT_W-1], prediction_state=cnt,
//   prediction_index=idx, prediction_history=GHR; GHR <= {GHR[HIST_W-2:0], cnt[CNT_W-1]}.
//   Latency: exactly 1 cycle from lookup to outputs.
//  Non-branch, not stalled: next edge prediction_valid=0, prediction=0; other outputs and GHR hold.
//  I_stall=1: all outputs, GHR and prediction_valid hold; update path still active.
//  Update (update_table=1): new = branch_taken ? sat_inc(branch_prediction_state)
//   : sat_dec(branch_prediction_state); table[branch_index] <= new. Saturate at all-ones / zero.
//   Uses the carried state, not a table read (no read-modify-write).
//  Mispredict = update_table && (branch_taken != branch_prediction_state[CNT_W-1]):
//   GHR <= {branch_history[HIST_W-2:0], branch_taken}. Correct prediction: GHR untouched by update.
//  Simultaneous lookup + update, same index: lookup uses the newly written value (write-first bypass).
//  Simultaneous lookup + mispredict: lookup indexes with current (pre-recovery) GHR, outputs are
//   produced normally; recovery value wins for GHR (speculative shift discarded).
//  HIST_W=0: GHR absent, idx = I_pc[IDX_W-1:0], history ports driven/ignored as 0.
//  Index wrap: PC bits above IDX_W ignored; aliasing is accepted behaviour.
// TESTING (defaults)
//  1 Reset, then I_instruction=32'hE4140078, I_pc=60 -> next cycle valid=1, prediction=0, state=01, index=6'h3C, history=0, GHR=0.
//  2 update_table=1, branch_index=60, branch_prediction_state=01, branch_taken=1, branch_history=0 -> entry60=10, GHR=0001;
//    then lookup I_pc=61 -> index 60, prediction=1, state=10, GHR=0011.
//  3 Saturation: update state 11 taken -> entry 11; update state 00 not-taken -> entry 00, no mispredict, GHR unchanged.
//  4 Same-cycle lookup I_pc=60 (GHR=0) and update index 60 state 01 taken -> prediction=1, state=10.
//  5 Train entries 10/11 at several indices, assert rst mid-cycle -> outputs reset immediately; re-lookup gives state 01.
//  6 I_instruction=0 -> valid=0, prediction=0, GHR held; I_stall=1 with branch -> all outputs and GHR held.

Source files
------------

// File: rtl/ceespu_gshare_predictor_if.sv
// Lookup, prediction and training signals between fetch/decode, the gshare predictor and execute.
// The master drives instructions and training data; the slave is the predictor itself.
interface ceespu_gshare_predictor_if #(
  parameter int PC_W   = 16,
  parameter int IDX_W  = 6,
  parameter int HIST_W = 4,
  parameter int CNT_W  = 2
);
  localparam int HW = (HIST_W > 0) ? HIST_W : 1;

  logic [31:0]      I_instruction;
  logic [PC_W-1:0]  I_pc;
  logic             I_stall;
  logic             prediction_valid;
  logic             prediction;
  logic [CNT_W-1:0] prediction_state;
  logic [IDX_W-1:0] prediction_index;
  logic [HW-1:0]    prediction_history;
  logic             update_table;
  logic [PC_W-1:0]  branch_address;
  logic [IDX_W-1:0] branch_index;
  logic [CNT_W-1:0] branch_prediction_state;
  logic [HW-1:0]    branch_history;
  logic             branch_taken;

  modport master (
    output I_instruction, I_pc, I_stall,
    output update_table, branch_address, branch_index,
    output branch_prediction_state, branch_history, branch_taken,
    input  prediction_valid, prediction, prediction_state,
    input  prediction_index, prediction_history
  );

  modport slave (
    input  I_instruction, I_pc, I_stall,
    input  update_table, branch_address, branch_index,
    input  branch_prediction_state, branch_history, branch_taken,
    output prediction_valid, prediction, prediction_state,
    output prediction_index, prediction_history
  );
endinterface

// File: rtl/ceespu_gshare_predictor.sv
// Gshare branch predictor: saturating counters indexed by PC xor global history, with speculative
// history updated at lookup and restored from the carried history on a mispredict.
module ceespu_gshare_predictor #(
  parameter int         PC_W          = 16,
  parameter int         IDX_W         = 6,
  parameter int         HIST_W        = 4,
  parameter int         CNT_W         = 2,
  parameter logic [5:0] BRANCH_OPCODE = 6'h39
) (
  input logic                  clk,
  input logic                  rst,
  ceespu_gshare_predictor_if.slave bp
);
  localparam int               HW      = (HIST_W > 0) ? HIST_W : 1;
  localparam int               DEPTH   = 1 << IDX_W;
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] table_q [DEPTH];
  logic [HW-1:0]    ghr_q;
  logic             lookup;
  logic             mispredict;
  logic [IDX_W-1:0] lookup_idx;
  logic [CNT_W-1:0] lookup_cnt;
  logic [CNT_W-1:0] upd_cnt;
  logic             unused_bits;

  assign lookup     = !bp.I_stall && (bp.I_instruction[31:26] == BRANCH_OPCODE);
  assign mispredict = bp.update_table &&
                      (bp.branch_taken != bp.branch_prediction_state[CNT_W-1]);
  assign lookup_idx = bp.I_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    upd_cnt = bp.branch_prediction_state;
    if (bp.branch_taken && (bp.branch_prediction_state != '1))
      upd_cnt = bp.branch_prediction_state + 1'b1;
    else if (!bp.branch_taken && (bp.branch_prediction_state != '0))
      upd_cnt = bp.branch_prediction_state - 1'b1;
  end

  // Write-first bypass: a lookup hitting the entry being trained sees the new value.
  assign lookup_cnt = (bp.update_table && (bp.branch_index == lookup_idx)) ?
                      upd_cnt : table_q[lookup_idx];

  // NOTE: the counter table takes the async reset too, because rst must erase learned state at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= RST_CNT;
    end else if (bp.update_table) begin
      table_q[bp.branch_index] <= upd_cnt;
    end
  end

  generate
    if (HIST_W > 0) begin : g_hist
      logic [HW-1:0] ghr_d;

      // Recovery from execute overrides the speculative shift of a same-cycle lookup.
      always_comb begin
        ghr_d = ghr_q;
        if (mispredict)
          ghr_d = (bp.branch_history << 1) | HW'(bp.branch_taken);
        else if (lookup)
          ghr_d = (ghr_q << 1) | HW'(lookup_cnt[CNT_W-1]);
      end

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
      end
    end else begin : g_bimodal
      assign ghr_q = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp.prediction_valid   <= 1'b0;
      bp.prediction         <= 1'b0;
      bp.prediction_state   <= RST_CNT;
      bp.prediction_index   <= '0;
      bp.prediction_history <= '0;
    end else if (lookup) begin
      bp.prediction_valid   <= 1'b1;
      bp.prediction         <= lookup_cnt[CNT_W-1];
      bp.prediction_state   <= lookup_cnt;
      bp.prediction_index   <= lookup_idx;
      bp.prediction_history <= ghr_q;
    end else if (!bp.I_stall) begin
      bp.prediction_valid   <= 1'b0;
      bp.prediction         <= 1'b0;
    end
  end

  // Address and history bits that only matter for debug or in other parameterisations.
  assign unused_bits = ^{bp.branch_address, bp.I_pc[PC_W-1:IDX_W],
                         bp.I_instruction[25:0], bp.branch_history};
endmodule
